// File: rtl/io_pattern_sequencer.sv
// io_pattern_sequencer: drives the GPIO bring-up pattern 0x01..0x0A, all-ones, all-zeros onto the pads
module io_pattern_sequencer #(
  parameter int WIDTH  = 8,
  parameter int HOLD_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  output logic [WIDTH-1:0]  io_out,
  output logic [WIDTH-1:0]  io_oeb,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        step_o
);
  typedef enum logic {IDLE, DRIVE} state_t;
  state_t state, n_state;
  logic [3:0] n_step;
  logic [HOLD_W-1:0] cnt, n_cnt, hold_m1, n_hold;
  logic n_done;
  logic [WIDTH-1:0] n_out, n_oeb;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      step_o  <= '0;
      cnt     <= '0;
      hold_m1 <= '0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
      io_out  <= '0;
      io_oeb  <= '1;
    end else begin
      state   <= n_state;
      step_o  <= n_step;
      cnt     <= n_cnt;
      hold_m1 <= n_hold;
      done_o  <= n_done;
      busy_o  <= n_state == DRIVE;
      io_out  <= n_out;
      io_oeb  <= n_oeb;
    end
  end
  // Hold is stored as H-1 so a latched zero behaves as one cycle without widening the counter
  always_comb begin
    n_state = state;
    n_step  = step_o;
    n_cnt   = cnt;
    n_hold  = hold_m1;
    n_done  = 1'b0;
    if (state == IDLE) begin
      if (start_i) begin
        n_state = DRIVE;
        n_step  = 4'd1;
        n_hold  = (hold_cycles_i == '0) ? '0 : hold_cycles_i - HOLD_W'(1);
        n_cnt   = n_hold;
      end
    end else if (cnt != '0) n_cnt = cnt - HOLD_W'(1);
    else if (step_o == 4'd12) begin
      n_state = IDLE;
      n_done  = 1'b1;
    end else begin
      n_step = step_o + 4'd1;
      n_cnt  = hold_m1;
    end
    n_out = (n_step == 4'd11) ? '1 : (n_step <= 4'd10) ? WIDTH'(n_step) : '0;
    n_oeb = (n_step == 4'd0) ? '1 : '0;
  end
endmodule

// File: tb/tb_io_pattern_sequencer.sv
// tb_io_pattern_sequencer: randomized and directed checks of the pattern sequencer against a step-table model
module tb_io_pattern_sequencer;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, start16 = 1'b0;
  logic [15:0] hold = '0, hold16 = '0;
  logic [7:0] io_out, io_oeb;
  logic [15:0] io_out16, io_oeb16;
  logic busy, done, busy16, done16;
  logic [3:0] step, step16;
  int total = 0, passed = 0;

  always #5 clk = ~clk;

  io_pattern_sequencer #(.WIDTH(8), .HOLD_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .hold_cycles_i(hold),
    .io_out(io_out), .io_oeb(io_oeb), .busy_o(busy), .done_o(done), .step_o(step));

  io_pattern_sequencer #(.WIDTH(16), .HOLD_W(16)) dut16 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start16), .hold_cycles_i(hold16),
    .io_out(io_out16), .io_oeb(io_oeb16), .busy_o(busy16), .done_o(done16), .step_o(step16));

  function automatic logic [15:0] pat(input int s, input int w);
    if (s <= 10) return 16'(s);
    if (s == 11) return 16'((32'd1 << w) - 1);
    return 16'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run: each of the 12 steps must be visible for exactly hexp cycles, then a single done pulse
  task automatic run(input logic [15:0] hin, input int hexp, input bit keep, input bit chg, input string nm);
    start = 1'b1;
    hold = hin;
    tick();
    start = keep;
    for (int s = 1; s <= 12; s++)
      for (int c = 0; c < hexp; c++) begin
        if (chg && s == 2 && c == 0) hold = 16'd2;
        total++;
        if (io_out !== 8'(pat(s, 8)) || step !== 4'(s) || busy !== 1'b1 || io_oeb !== 8'h00 || done !== 1'b0)
          $display("FAIL %s step%0d cyc%0d: out=%h step=%0d busy=%b oeb=%h done=%b, want out=%h step=%0d busy=1 oeb=00 done=0",
                   nm, s, c, io_out, step, busy, io_oeb, done, 8'(pat(s, 8)), s);
        else passed++;
        tick();
      end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || step !== 4'd12 || io_out !== 8'h00 || io_oeb !== 8'h00)
      $display("FAIL %s done: done=%b busy=%b step=%0d out=%h oeb=%h, want 1 0 12 00 00", nm, done, busy, step, io_out, io_oeb);
    else passed++;
  endtask

  task automatic do_reset();
    start = 1'b0;
    start16 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (io_out !== 8'h00 || io_oeb !== 8'hFF || busy !== 1'b0 || done !== 1'b0 || step !== 4'd0)
      $display("FAIL reset: out=%h oeb=%h busy=%b done=%b step=%0d, want 00 FF 0 0 0", io_out, io_oeb, busy, done, step);
    else passed++;
    total++;
    if (io_out16 !== 16'h0 || io_oeb16 !== 16'hFFFF || busy16 !== 1'b0 || step16 !== 4'd0)
      $display("FAIL reset16: out=%h oeb=%h busy=%b step=%0d, want 0000 FFFF 0 0", io_out16, io_oeb16, busy16, step16);
    else passed++;
  endtask

  task automatic test_basic();
    run(16'd4, 4, 1'b0, 1'b0, "h4");
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (io_out !== 8'h00 || io_oeb !== 8'h00 || step !== 4'd12 || done !== 1'b0 || busy !== 1'b0)
        $display("FAIL after_done cyc%0d: out=%h oeb=%h step=%0d done=%b busy=%b, want 00 00 12 0 0", i, io_out, io_oeb, step, done, busy);
      else passed++;
    end
  endtask

  task automatic test_min_hold();
    run(16'd0, 1, 1'b0, 1'b0, "h0");
    tick();
    run(16'd1, 1, 1'b0, 1'b0, "h1");
    tick();
  endtask

  task automatic test_start_ignored();
    run(16'd3, 3, 1'b1, 1'b0, "start_held");
    tick();
    total++;
    if (step !== 4'd1 || io_out !== 8'h01 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL restart: step=%0d out=%h busy=%b done=%b, want 1 01 1 0", step, io_out, busy, done);
    else passed++;
    do_reset();
  endtask

  task automatic test_abort();
    bit seen = 1'b0;
    start = 1'b1;
    hold = 16'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    total++;
    if (step !== 4'd7 || io_out !== 8'h07)
      $display("FAIL abort_pre: step=%0d out=%h, want 7 07", step, io_out);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (io_out !== 8'h00 || io_oeb !== 8'hFF || busy !== 1'b0 || step !== 4'd0 || done !== 1'b0)
      $display("FAIL abort: out=%h oeb=%h busy=%b step=%0d done=%b, want 00 FF 0 0 0", io_out, io_oeb, busy, step, done);
    else passed++;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) $display("FAIL abort_quiet: activity seen=%b, want 0", seen);
    else passed++;
  endtask

  task automatic test_hold_change();
    run(16'd5, 5, 1'b0, 1'b1, "hold_change");
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int h = $urandom_range(0, 7);
      run(16'(h), (h == 0) ? 1 : h, 1'($urandom_range(0, 1)), 1'b0, "random");
      do_reset();
    end
  endtask

  task automatic test_width16();
    start16 = 1'b1;
    hold16 = 16'd2;
    tick();
    start16 = 1'b0;
    for (int s = 1; s <= 12; s++)
      for (int c = 0; c < 2; c++) begin
        total++;
        if (io_out16 !== pat(s, 16) || step16 !== 4'(s) || io_oeb16 !== 16'h0 || busy16 !== 1'b1)
          $display("FAIL w16 step%0d: out=%h step=%0d oeb=%h busy=%b, want out=%h step=%0d oeb=0000 busy=1",
                   s, io_out16, step16, io_oeb16, busy16, pat(s, 16), s);
        else passed++;
        tick();
      end
    total++;
    if (done16 !== 1'b1 || io_out16 !== 16'h0 || io_oeb16 !== 16'h0)
      $display("FAIL w16_done: done=%b out=%h oeb=%h, want 1 0000 0000", done16, io_out16, io_oeb16);
    else passed++;
    tick();
    total++;
    if (done16 !== 1'b0 || io_out16 !== 16'h0 || io_oeb16 !== 16'h0)
      $display("FAIL w16_after: done=%b out=%h oeb=%h, want 0 0000 0000", done16, io_out16, io_oeb16);
    else passed++;
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_min_hold();
    test_start_ignored();
    test_abort();
    test_hold_change();
    test_random();
    test_width16();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
